// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter that lets N requesters share the write
//             port of a single-clock FIFO (fifo1 write side). A requester
//             is granted ownership for up to MAX_BURST beats, then gives the
//             port up and becomes lowest priority for the next arbitration.
//  Ports    : wclk        - clock (fifo1 write clock)
//             wrst        - synchronous active-high reset
//             req_valid   - per-requester data valid            [N]
//             req_data    - per-requester data, i at [i*DW+:DW] [N*DW]
//             req_ready   - per-requester accept                [N]
//             wfull       - fifo1 full flag
//             winc        - fifo1 write enable
//             wdata       - fifo1 write data                    [DW]
//             grant_vld   - a requester owns the write port
//             grant_id    - index of the current owner
//             wr_count    - running count of beats written (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int DW        = 8,
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  localparam int C_IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*DW-1:0]  req_data,
  output logic [N-1:0]     req_ready,
  input  logic             wfull,
  output logic             winc,
  output logic [DW-1:0]    wdata,
  output logic             grant_vld,
  output logic [C_IW-1:0]  grant_id,
  output logic [15:0]      wr_count
);

  localparam int C_BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [C_BW-1:0] C_LAST = C_BW'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            r_state;
  logic [C_IW-1:0]   r_owner;
  logic [C_IW-1:0]   r_rr_ptr;
  logic [C_BW-1:0]   r_burst_cnt;
  logic [15:0]       r_wr_count;

  logic              w_found;
  logic [C_IW-1:0]   w_pick;
  logic [C_IW-1:0]   w_next_ptr;
  logic              w_owner_valid;
  logic              w_ready;
  logic              w_accept;

  // Rotating priority search: first valid requester starting at r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N; k++) begin
      automatic int idx = (int'(r_rr_ptr) + k) % N;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = C_IW'(idx);
      end
    end
  end

  assign w_next_ptr    = (int'(r_owner) == N - 1) ? '0 : r_owner + 1'b1;
  assign w_owner_valid = req_valid[r_owner];

  // Reset is folded in so nothing is offered to fifo1 while wrst is held,
  // even in the cycle before the first reset edge has cleared the state.
  assign w_ready  = (r_state == S_GRANT) && !wfull && !wrst;
  assign w_accept = w_ready && w_owner_valid;

  always_comb begin
    req_ready          = '0;
    req_ready[r_owner] = w_ready;
  end

  assign winc      = w_accept;
  assign wdata     = req_data[int'(r_owner)*DW +: DW];
  assign grant_vld = (r_state == S_GRANT);
  assign grant_id  = r_owner;
  assign wr_count  = r_wr_count;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_wr_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_GRANT;
            r_owner     <= w_pick;
            r_burst_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (!w_owner_valid) begin
            // Owner withdrew: give the port up even when fifo1 is full.
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_ptr;
          end else if (w_accept) begin
            r_wr_count  <= r_wr_count + 16'd1;
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (r_burst_cnt == C_LAST) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end
          // Otherwise fifo1 is full: stall with owner and count held.
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter. A cycle table drives
//             the default instance; a MAX_BURST=1 instance exercises the
//             round-robin rotation and a long-burst instance the counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // default instance (DW=8, N=4, MAX_BURST=4)
  logic [3:0]  v, rdy;
  logic [31:0] d;
  logic        wf, winc, gvld;
  logic [7:0]  wdata;
  logic [1:0]  gid;
  logic [15:0] cnt;

  // round-robin instance (MAX_BURST=1)
  logic [3:0]  rr_v, rr_rdy;
  logic [31:0] rr_d;
  logic        rr_wf, rr_winc, rr_gvld;
  logic [7:0]  rr_wdata;
  logic [1:0]  rr_gid;
  logic [15:0] rr_cnt;

  // wrap instance (long bursts to keep the run short)
  logic [3:0]  wr_v, wr_rdy;
  logic [31:0] wr_d;
  logic        wr_wf, wr_winc, wr_gvld;
  logic [7:0]  wr_wdata;
  logic [1:0]  wr_gid;
  logic [15:0] wr_cnt;

  fifo_wr_arbiter #(.DW(8), .N(4), .MAX_BURST(4)) u_dut (
    .wclk(clk), .wrst(rst), .req_valid(v), .req_data(d), .req_ready(rdy),
    .wfull(wf), .winc(winc), .wdata(wdata), .grant_vld(gvld),
    .grant_id(gid), .wr_count(cnt));

  fifo_wr_arbiter #(.DW(8), .N(4), .MAX_BURST(1)) u_rr (
    .wclk(clk), .wrst(rst), .req_valid(rr_v), .req_data(rr_d), .req_ready(rr_rdy),
    .wfull(rr_wf), .winc(rr_winc), .wdata(rr_wdata), .grant_vld(rr_gvld),
    .grant_id(rr_gid), .wr_count(rr_cnt));

  fifo_wr_arbiter #(.DW(8), .N(4), .MAX_BURST(1024)) u_wrap (
    .wclk(clk), .wrst(rst), .req_valid(wr_v), .req_data(wr_d), .req_ready(wr_rdy),
    .wfull(wr_wf), .winc(wr_winc), .wdata(wr_wdata), .grant_vld(wr_gvld),
    .grant_id(wr_gid), .wr_count(wr_cnt));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [31:0] d;
    logic        wf;
    logic        e_winc;
    logic [7:0]  e_wdata;
    logic [3:0]  e_rdy;
    logic        e_gvld;
    logic [1:0]  e_gid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] iv, input logic [31:0] id,
                     input logic iwf, input logic ewinc, input logic [7:0] ewd,
                     input logic [3:0] erdy, input logic egv, input logic [1:0] egid,
                     input logic [15:0] ecnt);
    vec_t t;
    t.rst = r; t.v = iv; t.d = id; t.wf = iwf;
    t.e_winc = ewinc; t.e_wdata = ewd; t.e_rdy = erdy;
    t.e_gvld = egv; t.e_gid = egid; t.e_cnt = ecnt;
    tbl.push_back(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int beats;
    logic [31:0] act, exp;
    rst = 1'b1;
    v = '0; d = '0; wf = 1'b0;
    rr_v = '0; rr_d = '0; rr_wf = 1'b0;
    wr_v = '0; wr_d = '0; wr_wf = 1'b0;
    repeat (2) @(posedge clk);

    //   rst v       d              wf  winc wdata  rdy     gv gid cnt
    add(1, 4'h0, 32'h0,          0,  0, 8'h00, 4'h0, 0, 0, 0);   // reset state
    add(0, 4'h1, 32'd10,         0,  0, 8'h00, 4'h0, 0, 0, 0);   // arbitration bubble
    add(0, 4'h1, 32'd10,         0,  1, 8'd10, 4'h1, 1, 0, 0);
    add(0, 4'h1, 32'd11,         0,  1, 8'd11, 4'h1, 1, 0, 1);
    add(0, 4'h1, 32'd12,         0,  1, 8'd12, 4'h1, 1, 0, 2);
    add(0, 4'h1, 32'd13,         0,  1, 8'd13, 4'h1, 1, 0, 3);   // 4th beat, release
    add(0, 4'h1, 32'd14,         0,  0, 8'h00, 4'h0, 0, 0, 4);   // release bubble
    add(0, 4'h1, 32'd14,         0,  1, 8'd14, 4'h1, 1, 0, 4);
    add(0, 4'h0, 32'd14,         0,  0, 8'h00, 4'h1, 1, 0, 5);   // owner drops valid
    add(0, 4'h0, 32'h0,          0,  0, 8'h00, 4'h0, 0, 0, 5);
    add(0, 4'h4, 32'h0020_0000,  0,  0, 8'h00, 4'h0, 0, 0, 5);   // rr_ptr=1 -> req 2
    add(0, 4'h4, 32'h0020_0000,  0,  1, 8'h20, 4'h4, 1, 2, 5);
    add(0, 4'h4, 32'h0021_0000,  0,  1, 8'h21, 4'h4, 1, 2, 6);
    add(0, 4'h4, 32'h0022_0000,  1,  0, 8'h00, 4'h0, 1, 2, 7);   // stall x3
    add(0, 4'h4, 32'h0022_0000,  1,  0, 8'h00, 4'h0, 1, 2, 7);
    add(0, 4'h4, 32'h0022_0000,  1,  0, 8'h00, 4'h0, 1, 2, 7);
    add(0, 4'h4, 32'h0022_0000,  0,  1, 8'h22, 4'h4, 1, 2, 7);
    add(0, 4'h4, 32'h0023_0000,  0,  1, 8'h23, 4'h4, 1, 2, 8);   // release, rr_ptr=3
    add(0, 4'h0, 32'h0,          0,  0, 8'h00, 4'h0, 0, 2, 9);
    add(0, 4'h8, 32'h3000_0000,  0,  0, 8'h00, 4'h0, 0, 2, 9);   // -> req 3
    add(0, 4'h0, 32'h0,          0,  0, 8'h00, 4'h8, 1, 3, 9);   // zero-beat release, rr_ptr=0
    add(0, 4'hA, 32'h3000_1100,  0,  0, 8'h00, 4'h0, 0, 3, 9);   // -> req 1
    add(0, 4'hA, 32'h3000_1100,  0,  1, 8'h11, 4'h2, 1, 1, 9);
    add(0, 4'h8, 32'h3000_0000,  0,  0, 8'h00, 4'h2, 1, 1, 10);  // req 1 drops, rr_ptr=2
    add(0, 4'h8, 32'h3000_0000,  0,  0, 8'h00, 4'h0, 0, 1, 10);  // -> req 3
    add(0, 4'h8, 32'h3000_0000,  0,  1, 8'h30, 4'h8, 1, 3, 10);
    add(0, 4'h0, 32'h0,          1,  0, 8'h00, 4'h0, 1, 3, 11);  // drop while full
    add(0, 4'h0, 32'h0,          0,  0, 8'h00, 4'h0, 0, 3, 11);
    add(0, 4'h6, 32'h0024_1200,  0,  0, 8'h00, 4'h0, 0, 3, 11);  // rr_ptr=0 -> req 1
    add(0, 4'h6, 32'h0024_1200,  0,  1, 8'h12, 4'h2, 1, 1, 11);
    add(1, 4'h6, 32'h0024_1200,  0,  0, 8'h00, 4'h0, 1, 1, 12);  // reset mid-burst
    add(0, 4'h6, 32'h0024_1200,  0,  0, 8'h00, 4'h0, 0, 0, 0);
    add(0, 4'h6, 32'h0024_1200,  0,  1, 8'h12, 4'h2, 1, 1, 0);   // lowest valid index

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; v = tbl[i].v; d = tbl[i].d; wf = tbl[i].wf;
      #1;
      act = {winc, (tbl[i].e_winc ? wdata : 8'h00), rdy, gvld, gid, cnt};
      exp = {tbl[i].e_winc, tbl[i].e_wdata, tbl[i].e_rdy, tbl[i].e_gvld,
             tbl[i].e_gid, tbl[i].e_cnt};
      check($sformatf("vec%0d", i), act, exp);
    end
    @(negedge clk);
    rst = 1'b0; v = '0; wf = 1'b0;

    // Round robin with single-beat grants: bubble between every grant.
    rr_d = 32'h4433_2211;
    for (int c = 0; c < 10; c++) begin
      logic       eg;
      logic [1:0] eid;
      @(negedge clk);
      rr_v = 4'hF;
      #1;
      eg  = (c % 2) == 1;
      eid = eg ? 2'((c - 1) / 2) : 2'd0;
      act = {24'h0, rr_gvld, (rr_gvld ? rr_gid : 2'b00), rr_winc, rr_rdy};
      exp = {24'h0, eg, eid, eg, (eg ? (4'h1 << eid) : 4'h0)};
      check($sformatf("rr%0d", c), act, exp);
    end
    @(negedge clk);
    rr_v = '0;

    // Counter wrap: 65537 accepted beats leave wr_count at 1.
    wr_d  = 32'h0000_005A;
    wr_v  = 4'h1;
    beats = 0;
    for (int c = 0; c < 70000 && beats < 65537; c++) begin
      #1;
      if (wr_winc) beats++;
      if (beats < 65537) @(negedge clk);
    end
    check("wrap_beats", 32'(beats), 32'd65537);
    @(negedge clk);
    wr_v = '0;
    #1;
    check("wrap_count", {16'h0, wr_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
